// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 shift window,
// emitting one window per accepted pixel once a full neighbourhood exists (valid conv only).
module conv_window_gen #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] win_out [0:8],
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_done
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] lb0 [0:IMG_W-1];
    logic [DATA_W-1:0] lb1 [0:IMG_W-1];
    logic [DATA_W-1:0] win_q [0:8];
    logic [DATA_W-1:0] win_d [0:8];
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic              accept, col_end, row_end, emit;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col_q == CW'(IMG_W - 1));
    assign row_end  = (row_q == RW'(IMG_H - 1));
    // Rows/columns 0 and 1 only prime the window, which also masks stale data across frames.
    assign emit     = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign lb0_rd   = lb0[col_q];
    assign lb1_rd   = lb1[col_q];

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3+1];
                win_d[r*3 + 1] = win_q[r*3+2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = in_data;

            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end

            if (emit) begin
                out_valid_d = 1'b1;
                out_last_d  = row_end && col_end;
            end
            frame_done_d = row_end && col_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Line buffers carry no reset; their contents are only observed after being rewritten.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lb1[col_q] <= lb0_rd;
            lb0[col_q] <= in_data;
        end
    end

    assign win_out    = win_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: three instances (4x4, 5x4, 28x28) checked against a
// queue of expected windows built directly from pixel coordinates.
module tb_conv_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] drv_data;
    logic        drv_valid, drv_ready;
    logic [1:0]  sel;
    logic [2:0]  in_valid_v, in_ready_v, out_valid_v, out_last_v, frame_done_v;
    logic [31:0] win0 [0:8];
    logic [31:0] win1 [0:8];
    logic [31:0] win2 [0:8];

    logic        cur_valid, cur_last, cur_fd, cur_in_ready;
    logic [31:0] cur_win [0:8];

    typedef struct packed {
        logic [8:0][31:0] w;
        logic             last;
        logic [15:0]      idx;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int fd_cnt = 0;
    int last_acc_idx = -1;
    int last_acc_cyc = -1;
    bit lat_chk = 1'b0;
    bit rand_rdy = 1'b0;

    assign in_valid_v = drv_valid ? (3'b001 << sel) : 3'b000;

    conv_window_gen #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) u_dut_4x4 (
        .clk(clk), .rst(rst), .in_data(drv_data), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .win_out(win0), .out_valid(out_valid_v[0]),
        .out_ready(drv_ready), .out_last(out_last_v[0]), .frame_done(frame_done_v[0])
    );

    conv_window_gen #(.DATA_W(32), .IMG_W(5), .IMG_H(4)) u_dut_5x4 (
        .clk(clk), .rst(rst), .in_data(drv_data), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .win_out(win1), .out_valid(out_valid_v[1]),
        .out_ready(drv_ready), .out_last(out_last_v[1]), .frame_done(frame_done_v[1])
    );

    conv_window_gen #(.DATA_W(32), .IMG_W(28), .IMG_H(28)) u_dut_28x28 (
        .clk(clk), .rst(rst), .in_data(drv_data), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .win_out(win2), .out_valid(out_valid_v[2]),
        .out_ready(drv_ready), .out_last(out_last_v[2]), .frame_done(frame_done_v[2])
    );

    always_comb begin
        cur_valid    = out_valid_v[sel];
        cur_last     = out_last_v[sel];
        cur_fd       = frame_done_v[sel];
        cur_in_ready = in_ready_v[sel];
        for (int i = 0; i < 9; i++) begin
            cur_win[i] = win0[i];
            if (sel == 2'd1) cur_win[i] = win1[i];
            else if (sel == 2'd2) cur_win[i] = win2[i];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            drv_ready = 1'($urandom_range(1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: every valid 3x3 neighbourhood in raster order of its bottom-right pixel.
    task automatic expect_frame(input int w, input int h, input logic [31:0] base);
        exp_t e;
        for (int r = 2; r < h; r++) begin
            for (int c = 2; c < w; c++) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[i*3+j] = base + 32'((r - 2 + i) * w + (c - 2 + j));
                e.last = (r == h - 1) && (c == w - 1);
                e.idx  = 16'(r * w + c);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cur_valid && drv_ready) begin
            xfer_cnt++;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL extra_window: observed window w8=%h, expected no window", cur_win[8]);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < 9; i++)
                    chk($sformatf("win[%0d] px%0d", i, mon_e.idx), cur_win[i], mon_e.w[i]);
                chk($sformatf("out_last px%0d", mon_e.idx), 32'(cur_last), 32'(mon_e.last));
                if (lat_chk) begin
                    chk("latency_px", 32'(last_acc_idx), 32'(mon_e.idx));
                    chk("latency_cyc", 32'(last_acc_cyc), 32'(cyc));
                end
            end
        end
        if (!rst && cur_fd) begin
            fd_cnt++;
            chk("frame_done_with_last", 32'({cur_valid, cur_last}), 32'h3);
        end
    end

    task automatic send_px(input int idx, input logic [31:0] d, input bit gaps);
        int guard;
        int k;
        bit acc;
        k = 0;
        while (gaps && k < 8 && $urandom_range(1) == 0) begin
            drv_valid = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        drv_valid = 1'b1;
        drv_data  = d;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = cur_in_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (acc) begin
            last_acc_idx = idx;
            last_acc_cyc = cyc;
        end else begin
            tests++;
            fails++;
            $error("FAIL accept_timeout: observed no accept of px %0d in %0d cycles, expected accept",
                   idx, guard);
        end
        drv_valid = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input logic [31:0] base, input bit gaps);
        for (int i = 0; i < w * h; i++) send_px(i, base + 32'(i), gaps);
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, 32'(cur_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(cur_last), 32'd0);
        chk({tag, "_frame_done"}, 32'(cur_fd), 32'd0);
        chk({tag, "_in_ready"}, 32'(cur_in_ready), 32'd1);
        for (int i = 0; i < 9; i++) chk($sformatf("%s_win[%0d]", tag, i), cur_win[i], 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t first;
        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_data  = '0;
        drv_ready = 1'b1;
        sel       = 2'd0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        check_reset_state("reset");

        // 1: 4x4 at full throughput
        lat_chk = 1'b1; xfer_cnt = 0; fd_cnt = 0;
        expect_frame(4, 4, 32'd0);
        send_frame(4, 4, 32'd0, 1'b0);
        drain("s1");
        chk("s1_windows", 32'(xfer_cnt), 32'd4);
        chk("s1_frame_done", 32'(fd_cnt), 32'd1);

        // 2: downstream stall on the first window
        lat_chk = 1'b0; xfer_cnt = 0; fd_cnt = 0;
        expect_frame(4, 4, 32'd0);
        for (int i = 0; i <= 10; i++) send_px(i, 32'(i), 1'b0);
        drv_ready = 1'b0;
        drv_valid = 1'b1;
        drv_data  = 32'd11;
        first = exp_q[0];
        repeat (10) begin
            @(negedge clk);
            chk("s2_in_ready", 32'(cur_in_ready), 32'd0);
            chk("s2_out_valid", 32'(cur_valid), 32'd1);
            for (int i = 0; i < 9; i++) chk($sformatf("s2_hold[%0d]", i), cur_win[i], first.w[i]);
            @(posedge clk); #1;
        end
        drv_ready = 1'b1;
        for (int i = 11; i < 16; i++) send_px(i, 32'(i), 1'b0);
        drain("s2");
        chk("s2_windows", 32'(xfer_cnt), 32'd4);
        chk("s2_frame_done", 32'(fd_cnt), 32'd1);

        // 3: 5x4 with random input gaps and random backpressure
        sel = 2'd1; xfer_cnt = 0; fd_cnt = 0;
        rand_rdy = 1'b1;
        expect_frame(5, 4, 32'h3F80_0000);
        send_frame(5, 4, 32'h3F80_0000, 1'b1);
        drain("s3");
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        drv_ready = 1'b1;
        chk("s3_windows", 32'(xfer_cnt), 32'd6);
        chk("s3_frame_done", 32'(fd_cnt), 32'd1);

        // 4: two back-to-back 4x4 frames
        sel = 2'd0; lat_chk = 1'b1; xfer_cnt = 0; fd_cnt = 0;
        expect_frame(4, 4, 32'd0);
        expect_frame(4, 4, 32'd100);
        send_frame(4, 4, 32'd0, 1'b0);
        send_frame(4, 4, 32'd100, 1'b0);
        drain("s4");
        chk("s4_windows", 32'(xfer_cnt), 32'd8);
        chk("s4_frame_done", 32'(fd_cnt), 32'd2);

        // 5: reset mid-frame, with a pixel offered during reset
        lat_chk = 1'b0; xfer_cnt = 0; fd_cnt = 0;
        for (int i = 0; i <= 9; i++) send_px(i, 32'(i), 1'b0);
        rst       = 1'b1;
        drv_valid = 1'b1;
        drv_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst       = 1'b0;
        drv_valid = 1'b0;
        check_reset_state("s5_reset");
        lat_chk = 1'b1;
        expect_frame(4, 4, 32'd0);
        send_frame(4, 4, 32'd0, 1'b0);
        drain("s5");
        chk("s5_windows", 32'(xfer_cnt), 32'd4);
        chk("s5_frame_done", 32'(fd_cnt), 32'd1);

        // 6: default 28x28 frame
        sel = 2'd2; xfer_cnt = 0; fd_cnt = 0;
        expect_frame(28, 28, 32'h0000_1000);
        send_frame(28, 28, 32'h0000_1000, 1'b0);
        drain("s6");
        chk("s6_windows", 32'(xfer_cnt), 32'd676);
        chk("s6_frame_done", 32'(fd_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
